// File: rtl/crc_32_frame_arbiter_pkg.sv
// CRC-32 constants and byte-level helpers shared by the frame arbiter and its CRC engine.
// The engine runs MSB-first on bit-reversed bytes, which gives the standard reflected CRC-32.
package crc_32_byte_constants_and_functions;

    localparam logic [31:0] CRC_POLY          = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INITIAL_VALUE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESULT
    } state_e;

    function automatic logic [7:0] revers_byts(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] not_reverse_4_byts(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = ~c[31-i];
        return r;
    endfunction

    function automatic logic [31:0] crc_step_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[7-i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_32_frame_arbiter_engine.sv
// Byte-serial CRC-32 register: one byte per enabled cycle, init has priority over en.
// crc_out is the finished (reflected and inverted) value of whatever has been absorbed so far.
module crc_32_byte_engine
    import crc_32_byte_constants_and_functions::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q, crc_d;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INITIAL_VALUE;
        end else if (en) begin
            crc_d = crc_step_byte(crc_q, revers_byts(data));
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= CRC_INITIAL_VALUE;
        else     crc_q <= crc_d;
    end

    assign crc_out = not_reverse_4_byts(crc_q);

endmodule

// File: rtl/crc_32_frame_arbiter.sv
// Round-robin, frame-granular sharing of one CRC-32 engine between NUM_REQ byte sources,
// with the finished CRC, owner ID and byte count returned on a valid/ready result port.
module crc_32_frame_arbiter
    import crc_32_byte_constants_and_functions::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int LEN_W   = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_crc,
    output logic [ID_W-1:0]      res_id,
    output logic [LEN_W-1:0]     res_len,
    output logic                 busy
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ID_W-1:0]   rr_pick;
    logic [ID_W:0]     cand;
    logic              crc_init, crc_en;
    logic [7:0]        byte_sel;

    // Walk offsets from farthest to nearest so the closest valid requester after last_grant wins.
    always_comb begin
        rr_pick = last_grant_q;
        cand    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (req_valid[cand[ID_W-1:0]]) rr_pick = cand[ID_W-1:0];
        end
    end

    assign byte_sel = req_data[{grant_q, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        req_ready    = '0;
        res_valid    = 1'b0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d  = rr_pick;
                    crc_init = 1'b1;
                    len_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    crc_en = 1'b1;
                    if (len_q != {LEN_W{1'b1}}) len_d = len_q + LEN_W'(1);
                    if (req_last[grant_q]) state_d = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
        end
    end

    crc_32_byte_engine u_engine (
        .clk     (clk),
        .rst     (rst),
        .init    (crc_init),
        .en      (crc_en),
        .data    (byte_sel),
        .crc_out (res_crc)
    );

    assign res_id  = grant_q;
    assign res_len = len_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_crc_32_frame_arbiter.sv
// Self-checking bench: known-answer frame table, hand-built hold/gap/reset sequences,
// and randomized multi-requester traffic checked against a table-free bitwise CRC-32 model.
module tb_crc_32_frame_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 16;
    localparam int ID_W    = 2;
    localparam int MAX_F   = 6;
    localparam int MAX_B   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_crc;
    logic [ID_W-1:0]      res_id;
    logic [LEN_W-1:0]     res_len;
    logic                 busy;

    int n_pass  = 0;
    int n_total = 0;
    int last_id = NUM_REQ - 1;

    typedef struct {
        int           id;
        int           n;
        logic [127:0] bytes;
        logic [31:0]  crc;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    crc_32_frame_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_crc   (res_crc),
        .res_id    (res_id),
        .res_len   (res_len),
        .busy      (busy)
    );

    // Reflected CRC-32 in its textbook LSB-first form with the reversed polynomial.
    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[k]) begin
            c = c ^ {24'h0, q[k]};
            for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input int id, input logic [7:0] b, input bit last);
        req_valid[id]         = 1'b1;
        req_data[8*id +: 8]   = b;
        req_last[id]          = last;
    endtask

    task automatic push_byte(input int id, input logic [7:0] b, input bit last);
        drive_byte(id, b, last);
        for (int n = 0; n < 20 && !req_ready[id]; n++) tick();
        if (!req_ready[id]) timeout("push_ready");
        tick();
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic collect(input string name, input logic [31:0] crc, input int id, input int len);
        for (int n = 0; n < 40 && !res_valid; n++) tick();
        if (!res_valid) begin
            timeout(name);
            return;
        end
        check({name, "_crc"}, res_crc, crc);
        check({name, "_id"},  32'(res_id), 32'(id));
        check({name, "_len"}, 32'(res_len), 32'(len));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({name, "_drop"}, 32'(res_valid), 32'd0);
        last_id = id;
    endtask

    task automatic run_vector(input string name, input vec_t v);
        drive_byte(v.id, v.bytes[7:0], v.n == 1);
        check({name, "_idle_ready"}, 32'(req_ready), 32'd0);
        tick();
        check({name, "_first_ready"}, 32'(req_ready), 32'(1 << v.id));
        for (int k = 0; k < v.n; k++) push_byte(v.id, v.bytes[8*k +: 8], k == v.n - 1);
        collect(name, v.crc, v.id, v.n);
    endtask

    // All requesters keep a frame pending, so results must come back in strict rotation.
    task automatic arb_run(input string name, input int nf, input int maxlen, input bit rand_ready);
        logic [7:0]          fb [NUM_REQ][MAX_F][MAX_B];
        int                  fl [NUM_REQ][MAX_F];
        int                  fi [NUM_REQ];
        int                  bi [NUM_REQ];
        int                  rc [NUM_REQ];
        logic [NUM_REQ-1:0]  hs;
        logic [7:0]          q[$];
        int                  exp_id;
        int                  done;
        int                  bad_ready;
        exp_id    = (last_id + 1) % NUM_REQ;
        done      = 0;
        bad_ready = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fi[i] = 0;
            bi[i] = 0;
            rc[i] = 0;
            for (int f = 0; f < MAX_F; f++) begin
                fl[i][f] = $urandom_range(1, maxlen);
                for (int b = 0; b < MAX_B; b++) fb[i][f][b] = 8'($urandom_range(0, 255));
            end
        end
        for (int cyc = 0; cyc < 4000 && done < nf * NUM_REQ; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fi[i] < nf) begin
                    drive_byte(i, fb[i][fi[i]][bi[i]], bi[i] == fl[i][fi[i]] - 1);
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($countones(req_ready) > 1) bad_ready++;
            hs = req_valid & req_ready;
            if (res_valid && res_ready) begin
                q.delete();
                for (int b = 0; b < fl[exp_id][rc[exp_id]]; b++) q.push_back(fb[exp_id][rc[exp_id]][b]);
                check({name, "_crc"}, res_crc, ref_crc(q));
                check({name, "_id"},  32'(res_id), 32'(exp_id));
                check({name, "_len"}, 32'(res_len), 32'(fl[exp_id][rc[exp_id]]));
                rc[exp_id]++;
                last_id = exp_id;
                exp_id  = (exp_id + 1) % NUM_REQ;
                done++;
            end
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i]) begin
                    bi[i]++;
                    if (bi[i] == fl[i][fi[i]]) begin
                        bi[i] = 0;
                        fi[i]++;
                    end
                end
            end
        end
        req_valid = '0;
        req_last  = '0;
        res_ready = 1'b0;
        if (done < nf * NUM_REQ) timeout(name);
        check({name, "_ready_onehot_violations"}, 32'(bad_ready), 32'd0);
    endtask

    initial begin : main
        logic [7:0]  q[$];
        logic [31:0] exp_b;
        vec_t        v;

        vecs[0] = '{0, 9, 128'h39_3837_3635_3433_3231, 32'hCBF4_3926};
        vecs[1] = '{2, 1, 128'h00,                     32'hD202_EF8D};
        vecs[2] = '{1, 1, 128'h61,                     32'hE8B7_BE43};
        vecs[3] = '{3, 3, 128'h63_6261,                32'h3524_41C2};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        res_ready = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_crc",   res_crc,        32'd0);
        check("rst_res_id",    32'(res_id),    32'd0);
        check("rst_res_len",   32'(res_len),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) run_vector($sformatf("vec%0d", k), vecs[k]);

        // Requester 0 pauses for three cycles after "1234"; the partial CRC and count must hold.
        for (int k = 0; k < 4; k++) push_byte(0, 8'(8'h31 + k), 1'b0);
        q = '{8'h31, 8'h32, 8'h33, 8'h34};
        for (int g = 0; g < 3; g++) begin
            check("gap_len",   32'(res_len),   32'd4);
            check("gap_crc",   res_crc,        ref_crc(q));
            check("gap_busy",  32'(busy),      32'd1);
            check("gap_ready", 32'(req_ready), 32'b0001);
            tick();
        end
        for (int k = 4; k < 9; k++) push_byte(0, 8'(8'h31 + k), k == 8);
        collect("gap", 32'hCBF4_3926, 0, 9);

        // Result held with res_ready low while requester 1 waits.
        push_byte(0, 8'h61, 1'b1);
        drive_byte(1, 8'h62, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_crc",   res_crc,        32'hE8B7_BE43);
            check("hold_id",    32'(res_id),    32'd0);
            check("hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hold_drop",       32'(res_valid), 32'd0);
        check("hold_idle_ready", 32'(req_ready), 32'd0);
        tick();
        check("hold_grant1",     32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        q     = '{8'h62};
        exp_b = ref_crc(q);
        collect("hold_r1", exp_b, 1, 1);

        // Reset in the middle of a frame drops it; the next frame starts clean.
        for (int k = 0; k < 4; k++) push_byte(1, 8'(8'h31 + k), 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res_crc",   res_crc,        32'd0);
        check("mid_rst_res_id",    32'(res_id),    32'd0);
        check("mid_rst_res_len",   32'(res_len),   32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        last_id = NUM_REQ - 1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mid_rst_no_result", 32'(res_valid), 32'd0);
        v       = vecs[0];
        v.id    = 3;
        run_vector("after_rst", v);

        arb_run("rr_1byte", 2, 1, 1'b0);
        arb_run("rand", MAX_F, MAX_B, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
